// File: rtl/projection_reader_pkg.sv
// Shared constants and types for the projection_reader slice: word widths,
// the reader state enum and the read tag carried alongside each issued address.
package proj_pkg;

  localparam int PROJ_W    = 54;
  localparam int BX_W      = 4;
  localparam int NUM_W     = 6;
  // Largest index width whose full count (2**MEM_SIZE) still fits in NUM_W bits.
  localparam int IDX_MAX_W = NUM_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READ
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/projection_reader_pipe_delay.sv
// Fixed-depth register delay line with async reset and a synchronous clear,
// used for the start->done chain and the read-tag alignment pipe.
module pipe_delay #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/projection_reader.sv
// Fetches a BX's projection count, then sweeps its projection memory and emits
// one aligned word per cycle. Define PROJ_READER_STATS_EN for the stat counters.
module projection_reader
  import proj_pkg::*;
#(
  parameter int MEM_SIZE = 5,
  parameter int TMUX     = 16,
  parameter int NUM_LAT  = 1,
  parameter int DATA_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               start,
  output logic [1:0]               done,
  input  logic [NUM_W-1:0]         number_in,
  input  logic [PROJ_W-1:0]        proj_in,
  output logic [MEM_SIZE+BX_W-1:0] read_add,
  output logic [PROJ_W-1:0]        proj_out,
  output logic                     proj_valid,
  output logic [MEM_SIZE-1:0]      proj_index,
  output logic                     truncated
`ifdef PROJ_READER_STATS_EN
  ,
  output logic [15:0]              stat_count,
  output logic [7:0]               stat_trunc
`endif
);

  localparam int CW    = MEM_SIZE + 1;
  localparam int AW    = MEM_SIZE + BX_W;
  localparam int BUD_W = $clog2(TMUX) + 1;
  localparam int FW    = $clog2(NUM_LAT + 1) + 1;
  localparam int LIMIT = TMUX - NUM_LAT - DATA_LAT - 1;
  localparam int MAXN  = 2 ** MEM_SIZE;

  state_e              state_q, state_d;
  logic [BX_W-1:0]     rd_bx_q, rd_bx_d;
  logic [AW-1:0]       read_add_q, read_add_d;
  logic [CW-1:0]       n_q, n_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [BUD_W-1:0]    bud_q, bud_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  tag_t                issue_q, issue_d;
  logic                trunc_q, trunc_d;
  logic [PROJ_W-1:0]   proj_out_q, proj_out_d;
  logic                proj_valid_q, proj_valid_d;
  logic [MEM_SIZE-1:0] proj_index_q, proj_index_d;
  logic [MEM_SIZE:0]   tag_out;

  always_comb begin
    state_d      = state_q;
    rd_bx_d      = rd_bx_q;
    read_add_d   = read_add_q;
    n_d          = n_q;
    idx_d        = idx_q;
    bud_d        = bud_q;
    fcnt_d       = fcnt_q;
    issue_d      = '0;
    trunc_d      = 1'b0;
    proj_valid_d = tag_out[MEM_SIZE];
    proj_index_d = tag_out[MEM_SIZE-1:0];
    proj_out_d   = tag_out[MEM_SIZE] ? proj_in : proj_out_q;

    if (start[0]) begin
      // A new BX abandons any sweep still running; tags already issued drain normally.
      rd_bx_d    = rd_bx_q + 1'b1;
      read_add_d = {rd_bx_d, {MEM_SIZE{1'b0}}};
      state_d    = FETCH;
      bud_d      = '0;
      fcnt_d     = '0;
      idx_d      = '0;
      trunc_d    = (state_q != IDLE);
    end else begin
      unique case (state_q)
        FETCH: begin
          if (fcnt_q == FW'(NUM_LAT)) begin
            n_d     = (int'(number_in) > MAXN) ? CW'(MAXN) : CW'(number_in);
            trunc_d = (int'(number_in) > MAXN);
            idx_d   = '0;
            state_d = (n_d == '0) ? IDLE : READ;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        READ: begin
          if (bud_q == BUD_W'(LIMIT)) begin
            state_d = IDLE;
            trunc_d = (idx_q < n_q);
          end else begin
            read_add_d    = {rd_bx_q, idx_q[MEM_SIZE-1:0]};
            issue_d.valid = 1'b1;
            issue_d.index = IDX_MAX_W'(idx_q[MEM_SIZE-1:0]);
            idx_d         = idx_q + 1'b1;
            if (bud_q != '1) bud_d = bud_q + 1'b1;
            if (idx_d == n_q) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    // Pipelined synchronous reset: wins over start[0] in the same cycle.
    if (start[1]) begin
      state_d      = IDLE;
      rd_bx_d      = '1;
      read_add_d   = '0;
      n_d          = '0;
      idx_d        = '0;
      bud_d        = '0;
      fcnt_d       = '0;
      issue_d      = '0;
      trunc_d      = 1'b0;
      proj_valid_d = 1'b0;
      proj_index_d = '0;
      proj_out_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_bx_q      <= '1;
      read_add_q   <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      bud_q        <= '0;
      fcnt_q       <= '0;
      issue_q      <= '0;
      trunc_q      <= 1'b0;
      proj_out_q   <= '0;
      proj_valid_q <= 1'b0;
      proj_index_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_bx_q      <= rd_bx_d;
      read_add_q   <= read_add_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      bud_q        <= bud_d;
      fcnt_q       <= fcnt_d;
      issue_q      <= issue_d;
      trunc_q      <= trunc_d;
      proj_out_q   <= proj_out_d;
      proj_valid_q <= proj_valid_d;
      proj_index_q <= proj_index_d;
    end
  end

  // Tag leaves the pipe in the same cycle its RAM word appears on proj_in.
  pipe_delay #(.STAGES(DATA_LAT), .WIDTH(MEM_SIZE + 1)) u_tag_pipe (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (start[1]),
    .d_i   ({issue_q.valid, issue_q.index[MEM_SIZE-1:0]}),
    .q_o   (tag_out)
  );

  // Not cleared by start[1], so the pipelined reset itself propagates down the chain.
  pipe_delay #(.STAGES(TMUX), .WIDTH(2)) u_done_pipe (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (1'b0),
    .d_i   (start),
    .q_o   (done)
  );

  assign read_add   = read_add_q;
  assign proj_out   = proj_out_q;
  assign proj_valid = proj_valid_q;
  assign proj_index = proj_index_q;
  assign truncated  = trunc_q;

`ifdef PROJ_READER_STATS_EN
  logic [15:0] stat_count_q;
  logic [7:0]  stat_trunc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_count_q <= '0;
      stat_trunc_q <= '0;
    end else if (start[1]) begin
      stat_count_q <= '0;
      stat_trunc_q <= '0;
    end else begin
      if (proj_valid_q && (stat_count_q != '1)) stat_count_q <= stat_count_q + 1'b1;
      if (trunc_q && (stat_trunc_q != '1)) stat_trunc_q <= stat_trunc_q + 1'b1;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_trunc = stat_trunc_q;
`endif

endmodule

// File: tb/tb_projection_reader.sv
// Bench for projection_reader: upstream memory model plus an event-schedule
// reference built from the count/clamp/budget rules, with directed abort cases.
module tb_projection_reader;
  import proj_pkg::*;

  localparam int MEM_SIZE = 5;
  localparam int TMUX     = 16;
  localparam int NUM_LAT  = 1;
  localparam int DATA_LAT = 3;
  localparam int LIMIT    = TMUX - NUM_LAT - DATA_LAT - 1;
  localparam int NMAX     = 1 << MEM_SIZE;
  localparam int AW       = MEM_SIZE + BX_W;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          start;
  logic [1:0]          done;
  logic [NUM_W-1:0]    number_in = '0;
  logic [PROJ_W-1:0]   proj_in = '0;
  logic [AW-1:0]       read_add;
  logic [PROJ_W-1:0]   proj_out;
  logic                proj_valid;
  logic [MEM_SIZE-1:0] proj_index;
  logic                truncated;
`ifdef PROJ_READER_STATS_EN
  logic [15:0]         stat_count;
  logic [7:0]          stat_trunc;
`endif

  projection_reader #(
    .MEM_SIZE(MEM_SIZE), .TMUX(TMUX), .NUM_LAT(NUM_LAT), .DATA_LAT(DATA_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .number_in(number_in), .proj_in(proj_in), .read_add(read_add),
    .proj_out(proj_out), .proj_valid(proj_valid), .proj_index(proj_index),
    .truncated(truncated)
`ifdef PROJ_READER_STATS_EN
    , .stat_count(stat_count), .stat_trunc(stat_trunc)
`endif
  );

  always #5 clk = ~clk;

  // Upstream: count array with 1-cycle latency, projection RAM + output reg with 3.
  logic [PROJ_W-1:0] proj_mem [16][NMAX];
  logic [NUM_W-1:0]  num_mem  [16];
  logic [PROJ_W-1:0] up_p1 = '0, up_p2 = '0;

  always @(posedge clk) begin
    number_in <= num_mem[read_add[MEM_SIZE +: BX_W]];
    up_p1     <= proj_mem[read_add[MEM_SIZE +: BX_W]][read_add[MEM_SIZE-1:0]];
    up_p2     <= up_p1;
    proj_in   <= up_p2;
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Expected events keyed by the clock edge after which they are visible.
  bit                  exp_v  [int];
  logic [MEM_SIZE-1:0] exp_i  [int];
  logic [PROJ_W-1:0]   exp_w  [int];
  bit                  exp_t  [int];
  logic [AW-1:0]       exp_ra [int];
  bit                  exp_d  [int];
  logic [PROJ_W-1:0]   last_w;
  logic [3:0]          model_bx;
  bit                  chk_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("proj_valid", 64'(proj_valid), 64'(exp_v.exists(edge_n)));
      if (exp_v.exists(edge_n)) begin
        check_eq("proj_index", 64'(proj_index), 64'(exp_i[edge_n]));
        last_w = exp_w[edge_n];
      end
      check_eq("proj_out", 64'(proj_out), 64'(last_w));
      check_eq("truncated", 64'(truncated), 64'(exp_t.exists(edge_n)));
      if (exp_ra.exists(edge_n)) check_eq("read_add", 64'(read_add), 64'(exp_ra[edge_n]));
      check_eq("done", 64'(done), exp_d.exists(edge_n) ? 64'd1 : 64'd0);
    end
  end

  task automatic model_restart();
    exp_v.delete(); exp_i.delete(); exp_w.delete();
    exp_t.delete(); exp_ra.delete(); exp_d.delete();
    model_bx = 4'hF;
    last_w   = '0;
  endtask

  // One BX slot of TMUX cycles; schedules what the spec rules predict for count cnt.
  task automatic do_bx(input int cnt);
    int s, n, iss;
    model_bx = model_bx + 4'd1;
    num_mem[model_bx] = NUM_W'(cnt);
    s   = edge_n + 1;
    n   = (cnt > NMAX) ? NMAX : cnt;
    iss = (n > LIMIT) ? LIMIT : n;
    exp_ra[s] = {model_bx, {MEM_SIZE{1'b0}}};
    exp_d[s + TMUX - 1] = 1'b1;
    if (cnt > NMAX) exp_t[s + NUM_LAT + 1] = 1'b1;
    if (n > LIMIT) exp_t[s + NUM_LAT + 2 + LIMIT] = 1'b1;
    for (int i = 0; i < iss; i++) begin
      exp_ra[s + NUM_LAT + 2 + i] = {model_bx, MEM_SIZE'(i)};
      exp_v[s + NUM_LAT + 2 + i + DATA_LAT + 1] = 1'b1;
      exp_i[s + NUM_LAT + 2 + i + DATA_LAT + 1] = MEM_SIZE'(i);
      exp_w[s + NUM_LAT + 2 + i + DATA_LAT + 1] = proj_mem[model_bx][i];
    end
    start = 2'b01;
    @(negedge clk) start = 2'b00;
    repeat (TMUX - 1) @(negedge clk);
  endtask

  // Unmodelled BX start used to get a sweep running before an abort.
  task automatic kick(input int cnt);
    for (int b = 0; b < 16; b++) num_mem[b] = NUM_W'(cnt);
    start = 2'b01;
    @(negedge clk) start = 2'b00;
  endtask

  int dir_cnt [6] = '{3, 0, 40, 32, 11, 12};

  initial begin
    reset = 1'b1;
    start = 2'b00;
    for (int b = 0; b < 16; b++) begin
      num_mem[b] = '0;
      for (int i = 0; i < NMAX; i++) proj_mem[b][i] = PROJ_W'({$urandom(), $urandom()});
    end
    repeat (3) @(negedge clk);
    check_eq("rst_read_add", 64'(read_add), 64'd0);
    check_eq("rst_proj_valid", 64'(proj_valid), 64'd0);
    check_eq("rst_proj_out", 64'(proj_out), 64'd0);
    check_eq("rst_proj_index", 64'(proj_index), 64'd0);
    check_eq("rst_truncated", 64'(truncated), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Directed counts, then random ones; 20 BXs also wrap rd_bx past F.
    model_restart();
    chk_en = 1'b1;
    foreach (dir_cnt[j]) do_bx(dir_cnt[j]);
    for (int j = 0; j < 14; j++) do_bx(int'($urandom_range(0, 63)));
    repeat (6) @(negedge clk);
    chk_en = 1'b0;

    // start[1] in the middle of a sweep.
    kick(20);
    repeat (8) @(negedge clk);
    check_eq("pre_sreset_valid", 64'(proj_valid), 64'd1);
    start = 2'b10;
    @(negedge clk) start = 2'b00;
    check_eq("sreset_read_add", 64'(read_add), 64'd0);
    check_eq("sreset_proj_out", 64'(proj_out), 64'd0);
    check_eq("sreset_truncated", 64'(truncated), 64'd0);
    for (int c = 0; c < TMUX + 2; c++) begin
      check_eq("sreset_valid", 64'(proj_valid), 64'd0);
      @(negedge clk);
    end
    model_restart();
    chk_en = 1'b1;
    do_bx(2);
    repeat (6) @(negedge clk);
    chk_en = 1'b0;

    // Asynchronous reset in the middle of a sweep, checked before any clock edge.
    kick(20);
    repeat (8) @(negedge clk);
    check_eq("pre_areset_valid", 64'(proj_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_valid", 64'(proj_valid), 64'd0);
    check_eq("areset_proj_out", 64'(proj_out), 64'd0);
    check_eq("areset_read_add", 64'(read_add), 64'd0);
    check_eq("areset_truncated", 64'(truncated), 64'd0);
    check_eq("areset_done", 64'(done), 64'd0);
    @(negedge clk) reset = 1'b0;
    model_restart();
    chk_en = 1'b1;
    do_bx(7);
    repeat (6) @(negedge clk);
    chk_en = 1'b0;

    // start = 11: the synchronous reset must win, so no fetch or sweep follows.
    for (int b = 0; b < 16; b++) num_mem[b] = NUM_W'(5);
    start = 2'b11;
    @(negedge clk) start = 2'b00;
    for (int c = 0; c < TMUX + 2; c++) begin
      check_eq("both_valid", 64'(proj_valid), 64'd0);
      check_eq("both_read_add", 64'(read_add), 64'd0);
      @(negedge clk);
    end
    model_restart();
    chk_en = 1'b1;
    do_bx(4);
    repeat (6) @(negedge clk);
    chk_en = 1'b0;

`ifdef PROJ_READER_STATS_EN
    start = 2'b10;
    @(negedge clk) start = 2'b00;
    check_eq("stat_count_clr", 64'(stat_count), 64'd0);
    check_eq("stat_trunc_clr", 64'(stat_trunc), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
